// File: rtl/gn_axis_byte_packer.sv
// gn_axis_byte_packer: packs narrow AXI-Stream beats little-endian into wide words, flushing partial words on tlast
module gn_axis_byte_packer #(
    parameter int unsigned P_S_AXIS_DWIDTH = 32'd8,
    parameter int unsigned P_M_AXIS_DWIDTH = 32'd32
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic [P_S_AXIS_DWIDTH-1:0]                     s_axis_tdata,
    input  logic                                           s_axis_tvalid,
    input  logic                                           s_axis_tlast,
    output logic                                           s_axis_tready,
    output logic [P_M_AXIS_DWIDTH-1:0]                     m_axis_tdata,
    output logic [P_M_AXIS_DWIDTH/P_S_AXIS_DWIDTH-1:0]     m_axis_tkeep,
    output logic                                           m_axis_tlast,
    output logic                                           m_axis_tvalid,
    input  logic                                           m_axis_tready
);
    localparam int unsigned S  = P_S_AXIS_DWIDTH;
    localparam int unsigned M  = P_M_AXIS_DWIDTH;
    localparam int unsigned N  = M / S;
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned AW = M - S;
    logic [IW-1:0] idx_q, idx_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [M-1:0]  data_q, data_d, lane_w, word_w;
    logic [N-1:0]  keep_q, keep_d, keep_w;
    logic          last_q, last_d, valid_q, valid_d, accept, complete;
    assign s_axis_tready = !reset && (!valid_q || m_axis_tready);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign complete      = accept && (s_axis_tlast || idx_q == IW'(N - 1));
    assign lane_w        = M'(s_axis_tdata) << (32'(idx_q) * S);
    // accumulator lanes at and above idx are always zero, so OR-ing places the beat
    assign word_w        = {{S{1'b0}}, acc_q} | lane_w;
    for (genvar k = 0; k < N; k++) begin : g_keep
        assign keep_w[k] = idx_q >= IW'(k);
    end
    always_comb begin
        idx_d   = complete ? '0 : accept ? idx_q + 1'b1 : idx_q;
        acc_d   = complete ? '0 : accept ? acc_q | lane_w[AW-1:0] : acc_q;
        data_d  = complete ? word_w : data_q;
        keep_d  = complete ? keep_w : keep_q;
        last_d  = complete ? s_axis_tlast : last_q;
        valid_d = complete || (valid_q && !m_axis_tready);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q   <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end
    assign m_axis_tdata  = data_q;
    assign m_axis_tkeep  = keep_q;
    assign m_axis_tlast  = last_q;
    assign m_axis_tvalid = valid_q;
endmodule

// File: tb/tb_gn_axis_byte_packer.sv
// tb_gn_axis_byte_packer: directed and random checks of the 8-to-32 byte packer
module tb_gn_axis_byte_packer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0, s_last = 1'b0, s_ready;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last, m_valid;
    logic        m_ready = 1'b1;
    int          tests = 0, fails = 0;
    logic [36:0] got[$], expq[$];
    logic [31:0] part = '0;
    int          pn = 0;
    bit          done = 1'b0;

    gn_axis_byte_packer dut (
        .clk(clk), .reset(reset),
        .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tlast(s_last), .s_axis_tready(s_ready),
        .m_axis_tdata(m_data), .m_axis_tkeep(m_keep), .m_axis_tlast(m_last), .m_axis_tvalid(m_valid),
        .m_axis_tready(m_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        @(negedge clk);
        while (!s_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("send_timeout", 0, 1);
        step();
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [31:0] d, input logic [3:0] k, input logic l);
        for (int i = 0; i < 100 && got.size() == 0; i++) step();
        if (got.size() == 0) chk({tag, "_timeout"}, 0, 1);
        else chk(tag, got.pop_front(), {l, k, d});
    endtask

    // byte-level reference: rebuilds expected words from accepted beats
    always @(negedge clk) begin
        if (reset) begin
            part = '0;
            pn = 0;
            expq.delete();
        end else begin
            if (m_valid && m_ready) begin
                got.push_back({m_last, m_keep, m_data});
                chk("keep_contig", 64'(m_keep == 4'h1 || m_keep == 4'h3 || m_keep == 4'h7 || m_keep == 4'hF), 1);
                if (expq.size() == 0) chk("sb_unexpected", {m_last, m_keep, m_data}, 0);
                else chk("sb_word", {m_last, m_keep, m_data}, expq.pop_front());
            end
            if (s_valid && s_ready) begin
                part = part | (32'(s_data) << (8 * pn));
                pn++;
                if (pn == 4 || s_last) begin
                    expq.push_back({s_last, 4'((5'd1 << pn) - 5'd1), part});
                    part = '0;
                    pn = 0;
                end
            end
        end
    end

    initial begin
        repeat (3) step();
        chk("rst_valid", m_valid, 0);
        chk("rst_ready", s_ready, 0);
        chk("rst_out", {m_last, m_keep, m_data}, 0);
        reset = 1'b0;
        // full words, back-to-back
        for (int i = 1; i <= 8; i++) begin
            send(8'(8'h11 * i), i == 8);
            chk("t1_sready", s_ready, 1);
            if (i == 4) chk("t1_lat1", {m_valid, m_data}, {1'b1, 32'h44332211});
            if (i == 8) chk("t1_lat2", {m_valid, m_data}, {1'b1, 32'h88776655});
        end
        idle();
        expect_word("t1_w1", 32'h44332211, 4'hF, 1'b0);
        expect_word("t1_w2", 32'h88776655, 4'hF, 1'b1);
        // partial flush
        send(8'hA1, 0); send(8'hB2, 0); send(8'hC3, 1); send(8'hD4, 1);
        idle();
        expect_word("t2_w1", 32'h00C3B2A1, 4'h7, 1'b1);
        expect_word("t2_w2", 32'h000000D4, 4'h1, 1'b1);
        // back-pressure
        step();
        m_ready = 1'b0;
        fork
            for (int i = 1; i <= 8; i++) send(8'(i), i == 8);
            begin
                for (int i = 0; i < 10; i++) begin
                    step();
                    if (i >= 5) begin
                        chk("t3_hold_v", m_valid, 1);
                        chk("t3_hold_d", {m_keep, m_data}, {4'hF, 32'h04030201});
                        chk("t3_sready", s_ready, 0);
                    end
                end
                m_ready = 1'b1;
            end
        join
        idle();
        expect_word("t3_w1", 32'h04030201, 4'hF, 1'b0);
        expect_word("t3_w2", 32'h08070605, 4'hF, 1'b1);
        repeat (5) step();
        chk("t3_nodup", got.size(), 0);
        // input gaps
        send(8'h10, 0); send(8'h20, 0);
        idle();
        for (int i = 0; i < 20; i++) begin
            step();
            if (i % 5 == 4) chk("t4_gap", m_valid, 0);
        end
        send(8'h30, 0); send(8'h40, 0);
        idle();
        expect_word("t4_w", 32'h40302010, 4'hF, 1'b0);
        // reset mid-word
        send(8'hEE, 0); send(8'hFF, 0);
        idle();
        reset = 1'b1;
        step();
        chk("t5_rst_v", m_valid, 0);
        chk("t5_rst_r", s_ready, 0);
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) send(8'(i), i == 4);
        idle();
        expect_word("t5_w", 32'h04030201, 4'hF, 1'b1);
        repeat (5) step();
        chk("t5_only", got.size(), 0);
        // random throughput, checked by the reference model
        got.delete();
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    if ($urandom_range(0, 9) < 3) begin
                        idle();
                        repeat ($urandom_range(1, 3)) step();
                    end
                    send(8'($urandom_range(0, 255)), $urandom_range(0, 9) == 0);
                end
                idle();
                done = 1'b1;
            end
            while (!done) begin
                m_ready = $urandom_range(0, 3) != 0;
                step();
            end
        join
        m_ready = 1'b1;
        send(8'h5A, 1);
        idle();
        repeat (10) step();
        chk("t6_sb_empty", expq.size(), 0);
        chk("t6_partial", pn, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
